// File: rtl/sw_debounce.sv
// Switch input conditioning: per-bit two-flop synchroniser, stable-count debounce
// filter and change pulses. Interrupt request logic is built only with SW_DEBOUNCE_IRQ_EN.
module sw_debounce #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] sw_i,
  input  logic [WIDTH-1:0] sw_mask_i,
  input  logic             int_fin_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_changed_o,
  output logic             int_req_o
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            sw_q, sw_d;
  logic [WIDTH-1:0]            chg_q, chg_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Filter: a bit adopts its synchronised value only after STABLE_CYCLES
  // consecutive differing samples; any agreeing sample discards the count.
  always_comb begin
    sync1_d = sw_i;
    sync2_d = sync1_q;
    sw_d    = sw_q;
    chg_d   = '0;
    cnt_d   = cnt_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (sync2_q[b] == sw_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] < CNT_LAST) begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end else begin
        sw_d[b]  = sync2_q[b];
        chg_d[b] = 1'b1;
        cnt_d[b] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      chg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o         = sw_q;
  assign sw_changed_o = chg_q;

`ifdef SW_DEBOUNCE_IRQ_EN
  logic int_req_q, int_req_d;

  // Sticky request: a masked-in change sets it and outranks a same-edge acknowledge.
  always_comb begin
    int_req_d = int_req_q;
    if (|(chg_d & sw_mask_i)) begin
      int_req_d = 1'b1;
    end else if (int_fin_i) begin
      int_req_d = 1'b0;
    end else begin
      int_req_d = int_req_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= int_req_d;
    end
  end

  assign int_req_o = int_req_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{sw_mask_i, int_fin_i};
  assign int_req_o         = 1'b0;
`endif

endmodule
